alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_ctrl_if.sv | 34 +++
 rtl/alu_seq_decode.sv | 50 +++++
 rtl/alu_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the MOV/ALU instruction sequencer.
// Instruction classes include HALT, which the decoder produces only when HALT_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    GET_A,
    GET_B,
    EXEC,
    STATUS,
    WRITE_RD,
    WRITE_IMM,
    ERR,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ARITH,
    CLS_CMP,
    CLS_MVN,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_cls_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction-source / datapath-control bundle for alu_seq_ctrl.
// master = the controller, slave = instruction source plus datapath.
interface alu_seq_ctrl_if #(
  parameter int RW = 3,
  parameter int IW = 16
);
  logic          s;
  logic [IW-1:0] in;
  logic          w;
  logic          err;
  logic [RW-1:0] rnum;
  logic          reg_write;
  logic [1:0]    vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic [1:0]    ALUop;
  logic [1:0]    shift;
  logic [IW-1:0] sximm8;

  modport master (
    input  s, in,
    output w, err, rnum, reg_write, vsel, loada, loadb, loadc, loads,
           asel, ALUop, shift, sximm8
  );

  modport slave (
    output s, in,
    input  w, err, rnum, reg_write, vsel, loada, loadb, loadc, loads,
           asel, ALUop, shift, sximm8
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational instruction-register field split, immediate sign extension and class decode.
// With HALT_EN defined opcode 111 decodes as HALT; otherwise it is illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int RW = 3,
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir,
  output logic [1:0]    op,
  output logic [RW-1:0] rn,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rm,
  output logic [1:0]    sh,
  output logic [IW-1:0] sximm8,
  output instr_cls_t    cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(IW-8){ir[7]}}, ir[7:0]};

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == 2'b10)      cls = CLS_MOV_IMM;
        else if (op == 2'b00) cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          2'b00, 2'b10: cls = CLS_ARITH;
          2'b01:        cls = CLS_CMP;
          default:      cls = CLS_MVN;
        endcase
      end
`ifdef HALT_EN
      OPC_HALT: cls = CLS_HALT;
`endif
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle Moore sequencer driving the register-file/shifter/ALU datapath for MOV and ALU ops.
// Optional HALT_EN macro: opcode 111 parks the controller in HALT until reset.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int RW = 3,
  parameter int IW = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_seq_ctrl_if.master bus
);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ir;

  logic [1:0]    op;
  logic [RW-1:0] rn;
  logic [RW-1:0] rd;
  logic [RW-1:0] rm;
  logic [1:0]    sh;
  logic [IW-1:0] sximm8;
  instr_cls_t    cls;

  logic          w_q;
  logic          err_q;
  logic [RW-1:0] rnum_q;
  logic          reg_write_q;
  logic [1:0]    vsel_q;
  logic          loada_q;
  logic          loadb_q;
  logic          loadc_q;
  logic          loads_q;
  logic          asel_q;
  logic [1:0]    aluop_q;
  logic [1:0]    shift_q;

  alu_seq_decode #(.RW(RW), .IW(IW)) u_decode (
    .ir     (ir),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.s) state_nxt = DECODE;
      DECODE: begin
        case (cls)
          CLS_MOV_IMM:          state_nxt = WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: state_nxt = GET_B;
          CLS_ARITH, CLS_CMP:   state_nxt = GET_A;
          CLS_HALT:             state_nxt = HALT;
          default:              state_nxt = ERR;
        endcase
      end
      GET_A:  state_nxt = GET_B;
      GET_B:  state_nxt = (cls == CLS_CMP) ? STATUS : EXEC;
      EXEC:   state_nxt = WRITE_RD;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the decode of the next state, so they align with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      w_q         <= 1'b1;
      err_q       <= 1'b0;
      rnum_q      <= '0;
      reg_write_q <= 1'b0;
      vsel_q      <= VSEL_C;
      loada_q     <= 1'b0;
      loadb_q     <= 1'b0;
      loadc_q     <= 1'b0;
      loads_q     <= 1'b0;
      asel_q      <= 1'b0;
      aluop_q     <= ALU_ADD;
      shift_q     <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.s) ir <= bus.in;

      w_q         <= 1'b0;
      err_q       <= 1'b0;
      rnum_q      <= '0;
      reg_write_q <= 1'b0;
      vsel_q      <= VSEL_C;
      loada_q     <= 1'b0;
      loadb_q     <= 1'b0;
      loadc_q     <= 1'b0;
      loads_q     <= 1'b0;
      asel_q      <= 1'b0;
      aluop_q     <= ALU_ADD;
      shift_q     <= 2'b00;

      case (state_nxt)
        IDLE: w_q <= 1'b1;
        GET_A: begin
          rnum_q  <= rn;
          loada_q <= 1'b1;
        end
        GET_B: begin
          rnum_q  <= rm;
          loadb_q <= 1'b1;
          shift_q <= sh;
        end
        EXEC: begin
          loadc_q <= 1'b1;
          // MOV reg reuses the adder with A forced to zero: 0 + shifted Rm.
          if (cls == CLS_MOV_REG) begin
            aluop_q <= ALU_ADD;
            asel_q  <= 1'b1;
          end else begin
            aluop_q <= op;
          end
        end
        STATUS: begin
          aluop_q <= ALU_SUB;
          loads_q <= 1'b1;
        end
        WRITE_RD: begin
          rnum_q      <= rd;
          vsel_q      <= VSEL_C;
          reg_write_q <= 1'b1;
        end
        WRITE_IMM: begin
          rnum_q      <= rn;
          vsel_q      <= VSEL_IMM;
          reg_write_q <= 1'b1;
        end
        ERR: err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.w         = w_q;
  assign bus.err       = err_q;
  assign bus.rnum      = rnum_q;
  assign bus.reg_write = reg_write_q;
  assign bus.vsel      = vsel_q;
  assign bus.loada     = loada_q;
  assign bus.loadb     = loadb_q;
  assign bus.loadc     = loadc_q;
  assign bus.loads     = loads_q;
  assign bus.asel      = asel_q;
  assign bus.ALUop     = aluop_q;
  assign bus.shift     = shift_q;
  assign bus.sximm8    = sximm8;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; expected control words are hand-derived per state.
// HALT_EN selects which behaviour the opcode-111 step expects.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.RW(3), .IW(16)) bus ();

  alu_seq_ctrl #(.RW(3), .IW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // {w, err, rnum, reg_write, vsel, loada, loadb, loadc, loads, asel, ALUop, shift}
  function automatic logic [16:0] ex(input logic w, input logic err, input logic [2:0] rnum,
                                     input logic rw, input logic [1:0] vsel, input logic la,
                                     input logic lb, input logic lc, input logic ls,
                                     input logic asel, input logic [1:0] aluop,
                                     input logic [1:0] shift);
    return {w, err, rnum, rw, vsel, la, lb, lc, ls, asel, aluop, shift};
  endfunction

  logic [16:0] obs;
  assign obs = {bus.w, bus.err, bus.rnum, bus.reg_write, bus.vsel, bus.loada, bus.loadb,
                bus.loadc, bus.loads, bus.asel, bus.ALUop, bus.shift};

  logic [16:0] idle_o;
  logic [16:0] zero_o;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_imm(input string tag, input logic [15:0] exp);
    nchk++;
    assert (bus.sximm8 === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.sximm8, exp);
    end
  endtask

  // Pulse s for one sample, then check the DECODE cycle (no enables).
  task automatic issue(input string tag, input logic [15:0] instr);
    bus.s  = 1'b1;
    bus.in = instr;
    cyc();
    bus.s  = 1'b0;
    bus.in = 16'hFFFF;
    chk(tag, zero_o);
  endtask

  initial begin
    idle_o = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_o = '0;
    reset  = 1'b1;
    bus.s  = 1'b0;
    bus.in = 16'h0000;
    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_idle", idle_o);
    chk_imm("reset_sximm8", 16'h0000);

    // MOV R1,#7
    issue("movi_decode", 16'hD107);
    cyc(); chk("movi_write", ex(0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    chk_imm("movi_sximm8", 16'h0007);
    cyc(); chk("movi_done", idle_o);

    // MOV R2,#-2 with s held high, then CMP R1,R3 accepted in the first IDLE cycle
    bus.s = 1'b1; bus.in = 16'hD2FE;
    cyc(); chk("movn_decode", zero_o);
    bus.in = 16'hA903;
    cyc(); chk("movn_write", ex(0, 0, 2, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    chk_imm("movn_sximm8", 16'hFFFE);
    cyc(); chk("movn_done", idle_o);
    cyc(); chk("cmp_decode", zero_o);
    bus.s = 1'b0; bus.in = 16'h0000;
    cyc(); chk("cmp_geta", ex(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); chk("cmp_getb", ex(0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(); chk("cmp_status", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0));
    cyc(); chk("cmp_done", idle_o);

    // ADD R2,R1,R3 LSL1
    issue("add_decode", 16'hA14B);
    cyc(); chk("add_geta", ex(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); chk("add_getb", ex(0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01));
    cyc(); chk("add_exec", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    cyc(); chk("add_write", ex(0, 0, 2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("add_done", idle_o);

    // MOV R4,R5 LSR (sh=10)
    issue("movr_decode", 16'hC095);
    cyc(); chk("movr_getb", ex(0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10));
    cyc(); chk("movr_exec", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0));
    cyc(); chk("movr_write", ex(0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("movr_done", idle_o);

    // MVN R6,R7
    issue("mvn_decode", 16'hB8C7);
    cyc(); chk("mvn_getb", ex(0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(); chk("mvn_exec", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0));
    cyc(); chk("mvn_write", ex(0, 0, 6, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("mvn_done", idle_o);

    // AND R1,R3,R0
    issue("and_decode", 16'hB320);
    cyc(); chk("and_geta", ex(0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); chk("and_getb", ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(); chk("and_exec", ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0));
    cyc(); chk("and_write", ex(0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("and_done", idle_o);

    // Illegal: opcode 000, then opcode 110 with op 01
    issue("ill0_decode", 16'h0000);
    cyc(); chk("ill0_err", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("ill0_done", idle_o);
    issue("ill1_decode", 16'hC800);
    cyc(); chk("ill1_err", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("ill1_done", idle_o);

    // Opcode 111 with s held afterwards
    bus.s = 1'b1; bus.in = 16'hE000;
    cyc(); chk("op7_decode", zero_o);
    bus.in = 16'hD107;
`ifdef HALT_EN
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("op7_halt", zero_o);
    end
`else
    cyc(); chk("op7_err", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.s = 1'b0;
    cyc(); chk("op7_done", idle_o);
    cyc(); chk("op7_idle", idle_o);
`endif
    bus.s = 1'b0;
    reset = 1'b1;
    cyc(); chk("op7_reset", idle_o);
    chk_imm("op7_reset_sximm8", 16'h0000);
    reset = 1'b0;

    // Reset during GET_B of an ADD aborts it
    issue("abort_decode", 16'hA14B);
    cyc(); chk("abort_geta", ex(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); chk("abort_getb", ex(0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01));
    reset = 1'b1;
    cyc(); chk("abort_reset", idle_o);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("abort_quiet", idle_o);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
